// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port RAM between the MEM stage (port 0) and the loader (port 1).
// One access per 3 cycles: IDLE latches the winner, ACCESS drives the RAM, RESP acks.
module ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter bit RR = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_gnt_id,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_input,
  output logic              o_ram_str,
  output logic              o_ram_sel,
  output logic              o_ram_ld,
  input  logic [DATA_W-1:0] i_ram_data
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  logic [1:0]        r_state;
  logic              r_we, r_id, r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              w_idle, w_access, w_resp, w_req, w_pick;
  assign w_idle   = r_state == IDLE;
  assign w_access = r_state == ACCESS;
  assign w_resp   = r_state == RESP;
  assign w_req    = i_req0 | i_req1;
  // On a tie, round-robin favours the port not served last; fixed priority favours port 0.
  assign w_pick   = i_req1 & (~i_req0 | (RR & ~r_last));
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_idle ? (w_req ? ACCESS : IDLE) : (w_access ? RESP : IDLE);
      if (w_idle && w_req) begin
        r_id    <= w_pick;
        r_we    <= w_pick ? i_we1 : i_we0;
        r_addr  <= w_pick ? i_addr1 : i_addr0;
        r_wdata <= w_pick ? i_wdata1 : i_wdata0;
      end
      if (w_access && !r_we) r_rdata <= i_ram_data;
      if (w_resp) r_last <= r_id;
    end
  end
  assign o_ack0        = w_resp & ~r_id;
  assign o_ack1        = w_resp & r_id;
  assign o_rdata       = r_rdata;
  assign o_busy        = ~w_idle;
  assign o_gnt_id      = ~w_idle & r_id;
  assign o_ram_address = w_access ? r_addr : '0;
  assign o_ram_input   = w_access ? r_wdata : '0;
  assign o_ram_str     = w_access & r_we;
  assign o_ram_sel     = w_access;
  assign o_ram_ld      = w_access & ~r_we;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter (RR=1 instance with a RAM model, RR=0 instance for priority).
module tb_ram_arbiter;
  logic clk = 1'b0, clr = 1'b1;
  always #5 clk = ~clk;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [9:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic ack0, ack1, busy, gnt_id, ram_str, ram_sel, ram_ld;
  logic [31:0] rdata, ram_input, ram_data;
  logic [9:0] ram_address;
  logic [31:0] mem [1024] = '{default: 32'h0};
  logic f_req0 = 0, f_req1 = 0;
  logic f_ack0, f_ack1, f_busy, f_gnt, f_str, f_sel, f_ld;
  logic [31:0] f_rdata, f_input;
  logic [9:0] f_address;
  int total = 0, bad = 0, f_ack1_cnt = 0, both_cnt = 0, str_in_clr = 0;
  logic [31:0] rd;
  int n;

  ram_arbiter #(.ADDR_W(10), .DATA_W(32), .RR(1'b1)) dut (
    .i_clk(clk), .i_clr(clr), .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata(rdata), .o_busy(busy), .o_gnt_id(gnt_id),
    .o_ram_address(ram_address), .o_ram_input(ram_input), .o_ram_str(ram_str),
    .o_ram_sel(ram_sel), .o_ram_ld(ram_ld), .i_ram_data(ram_data));

  ram_arbiter #(.ADDR_W(10), .DATA_W(32), .RR(1'b0)) dut_fp (
    .i_clk(clk), .i_clr(clr), .i_req0(f_req0), .i_req1(f_req1), .i_we0(1'b0), .i_we1(1'b0),
    .i_addr0(10'h001), .i_addr1(10'h002), .i_wdata0(32'h0), .i_wdata1(32'h0),
    .o_ack0(f_ack0), .o_ack1(f_ack1), .o_rdata(f_rdata), .o_busy(f_busy), .o_gnt_id(f_gnt),
    .o_ram_address(f_address), .o_ram_input(f_input), .o_ram_str(f_str),
    .o_ram_sel(f_sel), .o_ram_ld(f_ld), .i_ram_data(32'hC0DE0000));

  assign ram_data = mem[ram_address];
  always @(posedge clk) if (ram_str && ram_sel) mem[ram_address] <= ram_input;
  always @(posedge clk) if (clr && ram_str) str_in_clr++;
  always @(negedge clk) begin
    if (ack0 && ack1) both_cnt++;
    if (f_ack1) f_ack1_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit p, input bit w, input logic [9:0] a, input logic [31:0] d,
                        input string tag, output logic [31:0] r);
    @(negedge clk);
    if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    @(negedge clk);
    chk({tag, " str"}, ram_str, w);
    chk({tag, " ld"}, ram_ld, !w);
    chk({tag, " sel"}, ram_sel, 1);
    chk({tag, " addr"}, ram_address, a);
    @(negedge clk);
    chk({tag, " ack"}, p ? ack1 : ack0, 1);
    chk({tag, " other ack"}, p ? ack0 : ack1, 0);
    chk({tag, " gnt"}, gnt_id, p);
    r = rdata;
    if (p) req1 = 0; else req0 = 0;
  endtask

  initial begin
    // Reset held with both ports requesting
    req0 = 1; req1 = 1;
    repeat (3) @(negedge clk);
    chk("rst ack0", ack0, 0);
    chk("rst ack1", ack1, 0);
    chk("rst busy", busy, 0);
    chk("rst gnt", gnt_id, 0);
    chk("rst rdata", rdata, 0);
    chk("rst ram ctl", {ram_str, ram_sel, ram_ld}, 0);
    chk("rst ram addr", ram_address, 0);
    chk("rst ram input", ram_input, 0);
    chk("rst fp busy", f_busy, 0);
    clr = 0;
    @(negedge clk);
    chk("first tie gnt", gnt_id, 0);
    chk("first tie busy", busy, 1);
    @(negedge clk);
    chk("first tie ack0", ack0, 1);
    chk("first tie ack1", ack1, 0);
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("idle ram addr", ram_address, 0);
    // Write then read 0x005
    access(0, 1, 10'h005, 32'hDEADBEEF, "wr005", rd);
    access(0, 0, 10'h005, 32'h0, "rd005", rd);
    chk("rd005 data", rd, 32'hDEADBEEF);
    // Port-1 write to the top address; rdata must not move
    access(1, 1, 10'h3FF, 32'hA5A5A5A5, "wr3ff", rd);
    chk("wr3ff rdata held", rd, 32'hDEADBEEF);
    // Round robin with both ports held
    @(negedge clk);
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 10'h001; addr1 = 10'h002;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(ack0 || ack1) && n < 8);
      chk($sformatf("rr%0d ack1", k), ack1, k % 2);
      chk($sformatf("rr%0d ack0", k), ack0, 1 - (k % 2));
      chk($sformatf("rr%0d gnt", k), gnt_id, k % 2);
      chk($sformatf("rr%0d gap", k), n, k == 0 ? 2 : 3);
    end
    req0 = 0; req1 = 0;
    // Fixed priority instance
    @(negedge clk);
    f_req0 = 1; f_req1 = 1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(f_ack0 || f_ack1) && n < 8);
      chk($sformatf("fp%0d ack0", k), f_ack0, 1);
      chk($sformatf("fp%0d gnt", k), f_gnt, 0);
    end
    chk("fp ack1 never", f_ack1_cnt, 0);
    f_req0 = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!f_ack1 && n < 8);
    chk("fp port1 ack", f_ack1, 1);
    chk("fp port1 gnt", f_gnt, 1);
    chk("fp port1 rdata", f_rdata, 32'hC0DE0000);
    f_req1 = 0;
    // Boundary reads
    access(0, 0, 10'h3FF, 32'h0, "rd3ff", rd);
    chk("rd3ff data", rd, 32'hA5A5A5A5);
    access(0, 0, 10'h000, 32'h0, "rd000", rd);
    chk("rd000 data", rd, 32'h0);
    // Reset during ACCESS aborts the write
    access(0, 1, 10'h010, 32'h00000001, "wr010", rd);
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 10'h010; wdata0 = 32'h12345678;
    @(negedge clk);
    chk("abort pre str", ram_str, 1);
    #2 clr = 1;
    #1;
    chk("abort str low", ram_str, 0);
    chk("abort busy", busy, 0);
    @(negedge clk);
    chk("abort no ack", {ack0, ack1}, 0);
    req0 = 0;
    clr = 0;
    access(0, 0, 10'h010, 32'h0, "rd010", rd);
    chk("rd010 data", rd, 32'h00000001);
    chk("ram_str in clr", str_in_clr, 0);
    chk("acks together", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
